block_row_packer: RTL and testbench

Write-side sequencer for the 8x8 `LineBuffer` transpose stage. It accepts a raster-order serial stream of 12-bit samples over a valid/ready handshake and packs every 8 consecutive samples into an 8-lane row. It presents each row to `LineBuffer` with a one-cycle write strobe. After 8 rows it stops accepting input and issues the 8 read strobes that drain the block column by column, then returns to filling.

---
 rtl/block_row_packer.sv | 114 +++++++++++
 tb/tb_block_row_packer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_row_packer.sv
// Write-side sequencer for the 8x8 LineBuffer transpose: packs a serial sample stream
// into 8-lane rows with a write strobe, then issues 8 column read strobes per block.

module block_row_packer_lane #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (we) q <= d;
    end
endmodule

module block_row_packer #(
    parameter int DATA_W = 12,
    parameter int N      = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_drain_en,
    output logic [DATA_W-1:0] o_row0,
    output logic [DATA_W-1:0] o_row1,
    output logic [DATA_W-1:0] o_row2,
    output logic [DATA_W-1:0] o_row3,
    output logic [DATA_W-1:0] o_row4,
    output logic [DATA_W-1:0] o_row5,
    output logic [DATA_W-1:0] o_row6,
    output logic [DATA_W-1:0] o_row7,
    output logic              o_wr,
    output logic              o_rd,
    output logic [2:0]        o_row_idx,
    output logic [2:0]        o_col_idx,
    output logic              o_block_done
);
    typedef enum logic {FILL, DRAIN} state_t;

    localparam logic [2:0] LAST = 3'(N - 1);

    state_t                   state, state_nxt;
    logic [2:0]               col_cnt, row_cnt, rd_cnt;
    logic                     wr, done, xfer, rd;
    logic [N-1:0]             lane_we;
    logic [N-1:0][DATA_W-1:0] lanes;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= FILL;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        xfer      = i_valid & (state == FILL);
        // Read held off while the row-7 write strobe is still on the bus.
        rd        = (state == DRAIN) & i_drain_en & ~wr;
        case (state)
            FILL:  if (xfer && row_cnt == LAST && col_cnt == LAST) state_nxt = DRAIN;
            DRAIN: if (rd && rd_cnt == LAST)                       state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Counters wrap 7->0 on their own, so a completed block leaves all three at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_cnt <= '0;
            row_cnt <= '0;
            rd_cnt  <= '0;
            wr      <= 1'b0;
            done    <= 1'b0;
        end else begin
            wr   <= xfer && col_cnt == LAST;
            done <= rd && rd_cnt == LAST;
            if (xfer) begin
                col_cnt <= col_cnt + 3'd1;
                if (col_cnt == LAST) row_cnt <= row_cnt + 3'd1;
            end
            if (rd) rd_cnt <= rd_cnt + 3'd1;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
        assign lane_we[k] = xfer && (col_cnt == 3'(k));
        block_row_packer_lane #(.DATA_W(DATA_W)) u_lane (
            .clk  (i_clk),
            .rst_n(i_rst_n),
            .we   (lane_we[k]),
            .d    (i_data),
            .q    (lanes[k])
        );
    end

    assign o_ready      = (state == FILL);
    assign o_wr         = wr;
    assign o_rd         = rd;
    assign o_row_idx    = row_cnt;
    assign o_col_idx    = rd_cnt;
    assign o_block_done = done;
    assign o_row0       = lanes[0];
    assign o_row1       = lanes[1];
    assign o_row2       = lanes[2];
    assign o_row3       = lanes[3];
    assign o_row4       = lanes[4];
    assign o_row5       = lanes[5];
    assign o_row6       = lanes[6];
    assign o_row7       = lanes[7];
endmodule

// File: tb/tb_block_row_packer.sv
// Scoreboard bench for block_row_packer: expected rows/columns are queued when a block is
// driven and checked against a LineBuffer model as strobes appear.

module tb_block_row_packer;
    localparam int DW = 12;
    typedef logic [8*DW-1:0] row_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data = '0;
    logic          valid = 1'b0;
    logic          drain_en = 1'b1;
    logic          o_ready, o_wr, o_rd, o_block_done;
    logic [DW-1:0] o_row0, o_row1, o_row2, o_row3, o_row4, o_row5, o_row6, o_row7;
    logic [2:0]    o_row_idx, o_col_idx;

    block_row_packer #(.DATA_W(DW), .N(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid), .o_ready(o_ready),
        .i_drain_en(drain_en),
        .o_row0(o_row0), .o_row1(o_row1), .o_row2(o_row2), .o_row3(o_row3),
        .o_row4(o_row4), .o_row5(o_row5), .o_row6(o_row6), .o_row7(o_row7),
        .o_wr(o_wr), .o_rd(o_rd), .o_row_idx(o_row_idx), .o_col_idx(o_col_idx),
        .o_block_done(o_block_done)
    );

    always #5 clk = ~clk;

    int   total = 0, bad = 0, cyc = 0;
    row_t exp_rows[$], exp_cols[$];
    int   wr_cyc[$], rd_cyc[$], done_cyc[$];
    row_t lb[8];
    int   wp = 0, rp = 0;
    bit   prev_wr = 0;
    int   first_cyc;
    int   row_end_cyc[8];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic row_t mk_row(int base, int r);
        row_t v = '0;
        for (int k = 0; k < 8; k++) v[k*DW +: DW] = DW'(base + 8*r + k);
        return v;
    endfunction

    function automatic row_t mk_col(int base, int c);
        row_t v = '0;
        for (int r = 0; r < 8; r++) v[r*DW +: DW] = DW'(base + 8*r + c);
        return v;
    endfunction

    // Monitor + LineBuffer model, sampled mid-cycle once inputs and state are stable.
    always begin
        row_t cur, col, e;
        @(negedge clk);
        #3;
        if (rst_n) begin
            cur = {o_row7, o_row6, o_row5, o_row4, o_row3, o_row2, o_row1, o_row0};
            if (o_wr) begin
                wr_cyc.push_back(cyc);
                total++;
                if (exp_rows.size() == 0) begin
                    bad++; $display("FAIL wr_unexpected: got row %h, none expected", cur);
                end else begin
                    e = exp_rows.pop_front();
                    if (cur !== e) begin bad++; $display("FAIL wr_row: got %h want %h", cur, e); end
                end
                lb[wp] = cur;
                wp = (wp + 1) % 8;
            end
            if (o_rd) begin
                rd_cyc.push_back(cyc);
                col = '0;
                for (int r = 0; r < 8; r++) col[r*DW +: DW] = lb[r][rp*DW +: DW];
                total++;
                if (exp_cols.size() == 0) begin
                    bad++; $display("FAIL rd_unexpected: got col %h, none expected", col);
                end else begin
                    e = exp_cols.pop_front();
                    if (col !== e) begin bad++; $display("FAIL rd_col: got %h want %h", col, e); end
                end
                total++;
                if (o_col_idx !== 3'(rp)) begin
                    bad++; $display("FAIL col_idx: got %0d want %0d", o_col_idx, rp);
                end
                rp = (rp + 1) % 8;
            end
            if (o_block_done) done_cyc.push_back(cyc);
            total++;
            if (o_wr && (o_rd || prev_wr)) begin
                bad++; $display("FAIL strobe_rules: wr=%b rd=%b prev_wr=%b want no overlap", o_wr, o_rd, prev_wr);
            end
            prev_wr = o_wr;
        end else prev_wr = 0;
    end

    task automatic clear_logs();
        wr_cyc.delete(); rd_cyc.delete(); done_cyc.delete();
    endtask

    task automatic send_sample(input int v, input bit gaps, output int tcyc);
        int n = 0;
        bit sent = 0;
        tcyc = -1;
        while (!sent && n < 300) begin
            @(negedge clk);
            data  = DW'(v);
            valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (valid && o_ready) begin sent = 1; tcyc = cyc; end
            n++;
        end
        if (!sent) begin
            total++; bad++; $display("FAIL send_timeout: sample %0d not accepted, want accepted", v);
        end
    endtask

    task automatic push_block(input int base);
        for (int i = 0; i < 8; i++) begin
            exp_rows.push_back(mk_row(base, i));
            exp_cols.push_back(mk_col(base, i));
        end
    endtask

    task automatic send_block(input int base, input bit gaps);
        int t;
        push_block(base);
        for (int k = 0; k < 64; k++) begin
            send_sample(base + k, gaps, t);
            if (k == 0) first_cyc = t;
            if (k % 8 == 7) row_end_cyc[k/8] = t;
        end
    endtask

    task automatic wait_done(input int cnt);
        int n = 0;
        while (done_cyc.size() < cnt && n < 300) begin
            @(negedge clk);
            #4;
            n++;
        end
        total++;
        if (done_cyc.size() < cnt) begin
            bad++; $display("FAIL done_timeout: got %0d done pulses want %0d", done_cyc.size(), cnt);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        total++;
        if ({o_ready, o_wr, o_rd, o_block_done} !== 4'b1000) begin
            bad++; $display("FAIL %s_ctrl: got rdy/wr/rd/done=%b want 1000", tag, {o_ready, o_wr, o_rd, o_block_done});
        end
        total++;
        if ({o_row_idx, o_col_idx} !== 6'd0) begin
            bad++; $display("FAIL %s_idx: got row=%0d col=%0d want 0 0", tag, o_row_idx, o_col_idx);
        end
        total++;
        if ({o_row7, o_row6, o_row5, o_row4, o_row3, o_row2, o_row1, o_row0} !== '0) begin
            bad++; $display("FAIL %s_lanes: got %h want 0", tag,
                            {o_row7, o_row6, o_row5, o_row4, o_row3, o_row2, o_row1, o_row0});
        end
    endtask

    task automatic test_reset();
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_raster();
        clear_logs();
        drain_en = 1'b1;
        send_block(0, 0);
        @(negedge clk);
        valid = 1'b0;
        wait_done(1);
        total++;
        if (wr_cyc.size() != 8) begin
            bad++; $display("FAIL raster_wr_count: got %0d want 8", wr_cyc.size());
        end else
            for (int i = 0; i < 8; i++) begin
                total++;
                if (wr_cyc[i] - first_cyc != 8*(i+1)) begin
                    bad++; $display("FAIL raster_wr_cycle: got %0d want %0d", wr_cyc[i] - first_cyc, 8*(i+1));
                end
            end
        total++;
        if (rd_cyc.size() != 8) begin
            bad++; $display("FAIL raster_rd_count: got %0d want 8", rd_cyc.size());
        end else
            for (int i = 0; i < 8; i++) begin
                total++;
                if (rd_cyc[i] - first_cyc != 65 + i) begin
                    bad++; $display("FAIL raster_rd_cycle: got %0d want %0d", rd_cyc[i] - first_cyc, 65 + i);
                end
            end
        if (done_cyc.size() > 0) begin
            total++;
            if (done_cyc[0] - first_cyc != 73) begin
                bad++; $display("FAIL raster_done_cycle: got %0d want 73", done_cyc[0] - first_cyc);
            end
        end
        total++;
        if (o_ready !== 1'b1 || o_row_idx !== 3'd0) begin
            bad++; $display("FAIL raster_done_state: got ready=%b row_idx=%0d want 1 0", o_ready, o_row_idx);
        end
    endtask

    task automatic test_gaps();
        clear_logs();
        send_block(200, 1);
        @(negedge clk);
        valid = 1'b0;
        wait_done(1);
        total++;
        if (wr_cyc.size() != 8) begin
            bad++; $display("FAIL gaps_wr_count: got %0d want 8", wr_cyc.size());
        end else
            for (int i = 0; i < 8; i++) begin
                total++;
                if (wr_cyc[i] != row_end_cyc[i] + 1) begin
                    bad++; $display("FAIL gaps_wr_cycle: row %0d got %0d want %0d", i, wr_cyc[i], row_end_cyc[i] + 1);
                end
            end
        total++;
        if (rd_cyc.size() != 8) begin
            bad++; $display("FAIL gaps_rd_count: got %0d want 8", rd_cyc.size());
        end
    endtask

    task automatic test_drain_stall();
        int reads = 0, n = 0;
        clear_logs();
        drain_en = 1'b0;
        send_block(300, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            valid = 1'b0;
            #1;
            total++;
            if (o_rd !== 1'b0 || o_ready !== 1'b0 || o_col_idx !== 3'd0) begin
                bad++; $display("FAIL stall_hold: got rd=%b ready=%b col=%0d want 0 0 0", o_rd, o_ready, o_col_idx);
            end
        end
        while (reads < 8 && n < 60) begin
            @(negedge clk);
            drain_en = (n % 3) != 0;
            #1;
            total++;
            if (o_rd !== drain_en || o_ready !== 1'b0 || o_col_idx !== 3'(reads)) begin
                bad++; $display("FAIL stall_follow: got rd=%b ready=%b col=%0d want %b 0 %0d",
                                o_rd, o_ready, o_col_idx, drain_en, reads);
            end
            if (o_rd) reads++;
            n++;
        end
        wait_done(1);
        drain_en = 1'b1;
        total++;
        if (rd_cyc.size() != 8) begin
            bad++; $display("FAIL stall_rd_count: got %0d want 8", rd_cyc.size());
        end
    endtask

    task automatic test_back_to_back();
        int first2;
        clear_logs();
        drain_en = 1'b1;
        send_block(0, 0);
        send_block(100, 0);
        first2 = first_cyc;
        @(negedge clk);
        valid = 1'b0;
        wait_done(2);
        if (done_cyc.size() > 0) begin
            total++;
            if (first2 != done_cyc[0]) begin
                bad++; $display("FAIL b2b_first_xfer: got cycle %0d want %0d", first2, done_cyc[0]);
            end
        end
        total++;
        if (wr_cyc.size() != 16 || rd_cyc.size() != 16) begin
            bad++; $display("FAIL b2b_counts: got wr=%0d rd=%0d want 16 16", wr_cyc.size(), rd_cyc.size());
        end
    endtask

    task automatic test_reset_mid();
        int t;
        clear_logs();
        push_block(500);
        for (int k = 0; k < 37; k++) send_sample(500 + k, 0, t);
        @(negedge clk);
        valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        total++;
        if (wr_cyc.size() != 4) begin
            bad++; $display("FAIL midrst_wr_count: got %0d want 4", wr_cyc.size());
        end
        exp_rows.delete();
        exp_cols.delete();
        wp = 0;
        rp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        send_block(0, 0);
        @(negedge clk);
        valid = 1'b0;
        wait_done(1);
        total++;
        if (rd_cyc.size() != 8) begin
            bad++; $display("FAIL midrst_rd_count: got %0d want 8", rd_cyc.size());
        end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_gaps();
        test_drain_stall();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        total++;
        if (exp_rows.size() != 0 || exp_cols.size() != 0) begin
            bad++; $display("FAIL leftover: got rows=%0d cols=%0d pending want 0 0", exp_rows.size(), exp_cols.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule
